// File: rtl/puf_ctrl_pkg.sv
// rtl/puf_ctrl_pkg.sv - shared types, default timing constants and challenge rotate helper
//
// Contents:
//   puf_state_t      sequencer FSM state encoding
//   DEF_*            default cycle counts for clear, settle and race timeout
//   MAX_CW           widest challenge the rotate helper supports
//   rotl1(v, w)      rotate the low w bits of v left by one, upper bits forced to 0
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_RECORD,
        ST_DONE
    } puf_state_t;

    localparam int DEF_CLR_CYC     = 2;
    localparam int DEF_SETTLE_CYC  = 4;
    localparam int DEF_TIMEOUT_CYC = 64;

    localparam int MAX_CW = 64;

    // When w == MAX_CW the shift overflows to 0, so the mask becomes all ones.
    function automatic logic [MAX_CW-1:0] rotl1(input logic [MAX_CW-1:0] v, input int w);
        logic [MAX_CW-1:0] mask;
        mask  = (MAX_CW'(1) << w) - MAX_CW'(1);
        rotl1 = ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// rtl/puf_challenge_sequencer_if.sv - host-side request/response bundle of the PUF sequencer
//
// Signals:
//   start         request, sampled only while the sequencer is idle
//   challenge_in  base challenge, latched on an accepted start
//   busy          sequencer working on a request
//   resp_valid    one-cycle pulse, response complete
//   response      voted response, held until the next accepted start
//   timeout       sticky flag: some race of this request timed out
// Modports: master (host side), slave (sequencer side).
interface puf_challenge_sequencer_if #(
    parameter int CW = 32,
    parameter int RW = 8
);
    logic          start;
    logic [CW-1:0] challenge_in;
    logic          busy;
    logic          resp_valid;
    logic [RW-1:0] response;
    logic          timeout;

    modport master (
        output start, challenge_in,
        input  busy, resp_valid, response, timeout
    );

    modport slave (
        input  start, challenge_in,
        output busy, resp_valid, response, timeout
    );
endinterface

// File: rtl/puf_sync2.sv
// rtl/puf_sync2.sv - two-flop synchronizer for one asynchronous arbiter signal
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, clears both flops
//   d    asynchronous input
//   q    synchronized output, two cycles behind d
module puf_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/puf_challenge_sequencer.sv
// rtl/puf_challenge_sequencer.sv - arbiter-PUF challenge sequencer with per-bit majority voting
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   host           slave side of the request/response bundle
//   puf_challenge  challenge driven to the delay chain (current rotated challenge)
//   arb_rst        race arbiter reset, held high while idle, clearing and done
//   launch         one-cycle race launch pulse
//   arb_done       arbiter decision ready (asynchronous)
//   arb_result     arbiter winner (asynchronous, stable before arb_done rises)
module puf_challenge_sequencer
    import puf_ctrl_pkg::*;
#(
    parameter int CW          = 32,
    parameter int RW          = 8,
    parameter int VOTES       = 5,
    parameter int CLR_CYC     = DEF_CLR_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                       clk,
    input  logic                       rst,
    puf_challenge_sequencer_if.slave   host,
    output logic [CW-1:0]              puf_challenge,
    output logic                       arb_rst,
    output logic                       launch,
    input  logic                       arb_done,
    input  logic                       arb_result
);
    localparam int CNT_MAX = (TIMEOUT_CYC > CLR_CYC)
                           ? ((TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC)
                           : ((CLR_CYC > SETTLE_CYC) ? CLR_CYC : SETTLE_CYC);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int VI_W  = $clog2(VOTES + 1);
    localparam int BI_W  = $clog2(RW + 1);

    puf_state_t    state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CW-1:0] cur_chal, chal_n;
    logic [VI_W-1:0] vote_idx, vote_idx_n;
    logic [VI_W-1:0] vote_cnt, vote_cnt_n;
    logic [VI_W-1:0] vote_sum;
    logic [BI_W-1:0] bit_idx, bit_idx_n;
    logic [RW-1:0] response, response_n;
    logic          timeout_r, timeout_n;
    logic          rec_bit, rec_bit_n;
    logic          done_s, result_s;

    puf_sync2 u_sync_done   (.clk(clk), .rst(rst), .d(arb_done),   .q(done_s));
    puf_sync2 u_sync_result (.clk(clk), .rst(rst), .d(arb_result), .q(result_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            cur_chal  <= '0;
            vote_idx  <= '0;
            vote_cnt  <= '0;
            bit_idx   <= '0;
            response  <= '0;
            timeout_r <= 1'b0;
            rec_bit   <= 1'b0;
        end else begin
            cnt       <= cnt_n;
            cur_chal  <= chal_n;
            vote_idx  <= vote_idx_n;
            vote_cnt  <= vote_cnt_n;
            bit_idx   <= bit_idx_n;
            response  <= response_n;
            timeout_r <= timeout_n;
            rec_bit   <= rec_bit_n;
        end
    end

    // The vote being recorded is folded in before the majority decision.
    assign vote_sum = vote_cnt + VI_W'(rec_bit);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        chal_n     = cur_chal;
        vote_idx_n = vote_idx;
        vote_cnt_n = vote_cnt;
        bit_idx_n  = bit_idx;
        response_n = response;
        timeout_n  = timeout_r;
        rec_bit_n  = rec_bit;
        case (state)
            ST_IDLE: begin
                if (host.start) begin
                    state_n    = ST_CLEAR;
                    cnt_n      = '0;
                    chal_n     = host.challenge_in;
                    vote_idx_n = '0;
                    vote_cnt_n = '0;
                    bit_idx_n  = '0;
                    response_n = '0;
                    timeout_n  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt == CNT_W'(CLR_CYC - 1)) begin
                    state_n = ST_SETTLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    state_n = ST_LAUNCH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_n = ST_WAIT;
                cnt_n   = '0;
            end
            ST_WAIT: begin
                // A done on the last allowed cycle still wins over the timeout.
                if (done_s) begin
                    state_n   = ST_RECORD;
                    rec_bit_n = result_s;
                end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n   = ST_RECORD;
                    rec_bit_n = 1'b0;
                    timeout_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RECORD: begin
                cnt_n = '0;
                if (vote_idx + 1'b1 < VI_W'(VOTES)) begin
                    vote_cnt_n = vote_sum;
                    vote_idx_n = vote_idx + 1'b1;
                    state_n    = ST_CLEAR;
                end else begin
                    for (int i = 0; i < RW; i++) begin
                        if (bit_idx == BI_W'(i)) begin
                            response_n[i] = (vote_sum > VI_W'(VOTES / 2));
                        end
                    end
                    chal_n     = CW'(rotl1(MAX_CW'(cur_chal), CW));
                    vote_cnt_n = '0;
                    vote_idx_n = '0;
                    bit_idx_n  = bit_idx + 1'b1;
                    state_n    = (bit_idx + 1'b1 == BI_W'(RW)) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign puf_challenge   = cur_chal;
    assign arb_rst         = (state == ST_IDLE) || (state == ST_CLEAR) || (state == ST_DONE);
    assign launch          = (state == ST_LAUNCH);
    assign host.busy       = (state != ST_IDLE);
    assign host.resp_valid = (state == ST_DONE);
    assign host.response   = response;
    assign host.timeout    = timeout_r;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// tb/tb_puf_challenge_sequencer.sv - directed self-checking bench for puf_challenge_sequencer
module tb_puf_challenge_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] puf_challenge;
    logic        arb_rst, launch, arb_done, arb_result;

    int compared   = 0;
    int mismatched = 0;

    // arbiter model controls
    int   race_no   = 0;
    int   hang_race = 0;
    bit   use_tab   = 1'b0;
    logic tab [40];
    int   cd;

    always #5 clk = ~clk;

    puf_challenge_sequencer_if #(.CW(32), .RW(8)) host ();

    puf_challenge_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .host         (host),
        .puf_challenge(puf_challenge),
        .arb_rst      (arb_rst),
        .launch       (launch),
        .arb_done     (arb_done),
        .arb_result   (arb_result)
    );

    // Arbiter model: result fixed at launch, done 3 cycles later, dropped by arb_rst.
    initial begin
        arb_done   = 1'b0;
        arb_result = 1'b0;
        cd         = 0;
        forever begin
            @(negedge clk);
            if (arb_rst) begin
                arb_done = 1'b0;
                cd       = 0;
            end
            if (launch) begin
                race_no++;
                if (use_tab && race_no <= 40) arb_result = tab[race_no-1];
                else                          arb_result = puf_challenge[0];
                cd = 3;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0 && race_no != hang_race) arb_done = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] c, input int k);
        if (k == 0) return c;
        return (c << k) | (c >> (32 - k));
    endfunction

    task automatic run_req(input string tag, input logic [31:0] chal, input bit pulse,
                           input bit chk_chal, input int exp_cycles,
                           input logic [7:0] exp_resp, input logic exp_to);
        int   cycles;
        int   launches;
        logic prev_rst;
        @(negedge clk);
        host.start        = 1'b1;
        host.challenge_in = chal;
        @(negedge clk);
        cycles   = 1;
        launches = 0;
        prev_rst = 1'b0;
        chk({tag, "_accept"}, {61'd0, host.busy, arb_rst, host.timeout}, 64'h6);
        if (!pulse) host.start = 1'b0;
        while (!host.resp_valid && cycles < 2000) begin
            if (launch) launches++;
            if (chk_chal && arb_rst && !prev_rst)
                chk({tag, "_chal_clear"}, 64'(puf_challenge), 64'(rotl(chal, launches / 5)));
            if (chk_chal && launch)
                chk({tag, "_chal_launch"}, 64'(puf_challenge), 64'(rotl(chal, (launches - 1) / 5)));
            prev_rst = arb_rst;
            if (pulse) host.challenge_in = $urandom;
            @(negedge clk);
            cycles++;
        end
        host.start = 1'b0;
        chk({tag, "_latency"},  64'(cycles),   64'(exp_cycles));
        chk({tag, "_launches"}, 64'(launches), 64'd40);
        chk({tag, "_response"}, 64'(host.response), 64'(exp_resp));
        chk({tag, "_timeout"},  64'(host.timeout),  64'(exp_to));
        @(negedge clk);
        chk({tag, "_valid_once"}, {62'd0, host.resp_valid, host.busy}, 64'd0);
    endtask

    initial begin
        int launches;
        int rv_cnt;
        int busy_cnt;
        host.start        = 1'b0;
        host.challenge_in = 32'hDEAD_BEEF;
        for (int i = 0; i < 40; i++) tab[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {57'd0, host.busy, host.resp_valid, host.timeout, arb_rst, launch, 2'b00}, 64'h8);
        chk("reset_response",  64'(host.response), 64'd0);
        chk("reset_challenge", 64'(puf_challenge), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // basic request: result follows challenge bit 0
        race_no = 0;
        run_req("basic", 32'h0000_0001, 1'b0, 1'b0, 521, 8'h01, 1'b0);

        // majority voting from a fixed result table
        tab[0] = 1; tab[1] = 1; tab[2] = 0; tab[3] = 0; tab[4] = 1;
        tab[5] = 0; tab[6] = 0; tab[7] = 1; tab[8] = 0; tab[9] = 1;
        use_tab = 1'b1;
        race_no = 0;
        run_req("vote", 32'h0000_0001, 1'b0, 1'b0, 521, 8'h01, 1'b0);
        use_tab = 1'b0;

        // third race never completes: 64-cycle wait, vote counts as 0
        race_no   = 0;
        hang_race = 3;
        run_req("timeout", 32'h0000_0001, 1'b0, 1'b0, 580, 8'h01, 1'b1);
        hang_race = 0;

        // reset in the WAIT of bit 3 (race 16)
        race_no = 0;
        @(negedge clk);
        host.start        = 1'b1;
        host.challenge_in = 32'h0000_0001;
        @(negedge clk);
        host.start = 1'b0;
        chk("abort_timeout_cleared", 64'(host.timeout), 64'd0);
        launches = 0;
        for (int c = 0; c < 2000 && launches < 16; c++) begin
            if (launch) launches++;
            if (launches < 16) @(negedge clk);
        end
        chk("abort_reached_bit3", 64'(launches), 64'd16);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_response", 64'(host.response), 64'h01);
        rst = 1'b1;
        #1;
        chk("abort_outputs",
            {59'd0, host.busy, host.resp_valid, host.timeout, arb_rst, launch}, 64'h2);
        chk("abort_response",  64'(host.response), 64'd0);
        chk("abort_challenge", 64'(puf_challenge), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        rv_cnt   = 0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (host.resp_valid) rv_cnt++;
            if (host.busy)       busy_cnt++;
        end
        chk("abort_quiet", {32'(rv_cnt), 32'(busy_cnt)}, 64'd0);
        race_no = 0;
        run_req("after_abort", 32'h0000_0001, 1'b0, 1'b0, 521, 8'h01, 1'b0);

        // start pulsed and challenge_in scrambled every cycle while busy
        race_no = 0;
        run_req("busy_start", 32'h0000_0001, 1'b1, 1'b0, 521, 8'h01, 1'b0);

        // rotating challenge sequence
        race_no = 0;
        run_req("rotate", 32'h8000_0001, 1'b0, 1'b1, 521, 8'h03, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Controller for one arbiter-PUF race arbiter and its delay chain. On request it applies a challenge and clears the arbiter. It then launches a race and collects the arbiter decision, repeating VOTES times per bit and majority-voting the result. It assembles an RW-bit response by rotating the challenge between bits, and sits between the host/test logic and the race arbiter.

## Interface
- CW, 32: challenge width (≥2)
- RW, 8: response bits per request (1..CW)
- VOTES, 5: evaluations per response bit; must be odd, ≥1
- CLR_CYC, 2: cycles arb_rst is held high before each race
- SETTLE_CYC, 4: cycles challenge is held stable after clear, before launch
- TIMEOUT_CYC, 64: max cycles waited for arbiter done per race
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- challenge_in  in  CW  base challenge, latched on accepted start
- busy  out  1  high from cycle after accepted start until DONE exits
- resp_valid  out  1  one-cycle pulse, response complete
- response  out  RW  voted response; held until next accepted start
- timeout  out  1  sticky: some race hit TIMEOUT_CYC; cleared on accepted start
- puf_challenge  out  CW  challenge driven to the delay chain
- arb_rst  out  1  reset to the race arbiter
- launch  out  1  one-cycle race launch pulse into the chain
- arb_done  in  1  arbiter done; asynchronous, passed through 2-FF synchronizer
- arb_result  in  1  arbiter winner; asynchronous, 2-FF synchronized alongside arb_done

## Operation
- States: IDLE, CLEAR, SETTLE, LAUNCH, WAIT, RECORD, DONE.
- IDLE to CLEAR on start.
  - Latch challenge_in into cur_chal.
  - Clear bit_idx, vote_idx, vote_cnt, response and timeout.
- CLEAR: arb_rst=1 for CLR_CYC cycles, then SETTLE.
- SETTLE: arb_rst=0 for SETTLE_CYC cycles, then LAUNCH.
- puf_challenge = cur_chal at all times, including IDLE.
- LAUNCH: launch=1 for exactly one cycle, then WAIT. The timeout counter is cleared.
- WAIT:
  - On synchronized done=1, go to RECORD with sampled bit = synchronized result.
  - If the counter reaches TIMEOUT_CYC first, go to RECORD with bit=0 and set timeout.
- RECORD (one cycle):
  - vote_cnt += bit; vote_idx++.
  - If vote_idx < VOTES, go to CLEAR.
  - Otherwise:
    - response[bit_idx] = (vote_cnt > VOTES/2).
    - cur_chal = rotate-left-by-1(cur_chal).
    - Clear vote_cnt and vote_idx; bit_idx++.
    - If bit_idx == RW go to DONE, else go to CLEAR.
- DONE (one cycle): resp_valid=1, then IDLE.
- response[0] is the first bit evaluated, from the unrotated challenge.
- vote_cnt width is clog2(VOTES+1); bit_idx width is clog2(RW+1). No overflow is possible.
- start while busy is ignored. start held high in IDLE re-triggers after DONE, one cycle later.
- arb_done already high when WAIT is entered counts immediately. The arbiter is cleared every race, so a stale done means an arbiter fault, caught by the test plan.

## Timing
- Reset values: busy=0, resp_valid=0, response=0, timeout=0, puf_challenge=0, arb_rst=1, launch=0, state=IDLE.
- arb_rst stays 1 in IDLE and DONE, so the arbiter is parked in reset.
- rst mid-operation aborts immediately: all outputs return to reset values and synchronizer flops clear.
- start accepted at edge N: busy=1 and arb_rst=1 from N+1. The first launch is at cycle N+1+CLR_CYC+SETTLE_CYC.
- done-to-RECORD latency is 2 cycles for the synchronizer plus 1 cycle.
- Per race: CLR_CYC+SETTLE_CYC+1+W+1 cycles, where W is the WAIT duration.
- Total time is RW·VOTES times the per-race count, plus 1 for DONE.
- resp_valid is asserted the same cycle response holds its final value.
- busy falls the cycle after resp_valid.

## Structure
- Package puf_ctrl_pkg holds:
  - the state enum type;
  - the rotate function;
  - default constants for CLR_CYC, SETTLE_CYC and TIMEOUT_CYC.
- Sub-module puf_sync2: 2-flop synchronizer with async active-high reset to 0.
  - Instantiated twice, for arb_done and arb_result.
  - arb_result is valid before arb_done rises, so separate synchronization is safe.
- One cycle counter is shared by CLEAR, SETTLE and WAIT, reloaded on each state entry.

## Test plan
- Defaults, challenge_in=0x0000_0001. Model arbiter returns result=challenge[0] with done 3 cycles after launch.
  - Expect response=0x01 and resp_valid high for exactly 1 cycle.
  - Expect exactly 40 launch pulses and timeout=0.
- VOTES=5, model returns 1,1,0,0,1 for bit 0 and 0,0,1,0,1 for bit 1.
  - Expect response[0]=1 and response[1]=0.
- Model never asserts done on the 3rd race.
  - WAIT lasts 64 cycles; that vote counts as 0.
  - Expect timeout=1 at resp_valid; timeout clears on the next start.
- Assert rst during WAIT of bit 3, then release.
  - Expect busy=0, arb_rst=1, response=0 and no resp_valid.
  - A fresh start yields a normal result.
- Pulse start every cycle while busy.
  - Expect a single launch sequence of unchanged length.
  - challenge_in changes after acceptance must not affect puf_challenge.
- Check puf_challenge sequence for challenge_in=0x8000_0001.
  - Values per bit are 0x8000_0001, 0x0000_0003, 0x0000_0006, …
  - Each value must be stable from CLEAR through RECORD.
